// File: rtl/systolic_tile_sequencer_if.sv
// Operand stream into the tile sequencer: one shared A/W beat per handshake.
interface systolic_tile_sequencer_if #(
  parameter int INWIDTH = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic [INWIDTH-1:0] a_in;
  logic [INWIDTH-1:0] w_in;

  modport master (output in_valid, a_in, w_in, input in_ready);
  modport slave  (input in_valid, a_in, w_in, output in_ready);
endinterface

// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer: deinterleaves the A/W stream into per-row buffers, then
// issues row-skewed buffer reads, waits for the array to drain and pulses done.
module sts_row_lane #(
  parameter int TW  = 5,
  parameter int KW  = 5,
  parameter int ROW = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          feeding,
  input  logic          kill,
  input  logic [TW-1:0] t,
  input  logic [KW-1:0] k,
  output logic          rd,
  output logic          fv
);
  logic [31:0] t32, k32;
  logic        fv_d, fv_q;

  assign t32 = 32'(t);
  assign k32 = 32'(k);
  // Row ROW reads during its own k-cycle window, starting ROW cycles late.
  assign rd  = feeding && !kill && (t32 >= 32'(ROW)) && (t32 < 32'(ROW) + k32);

  always_comb begin
    fv_d = rd;
    if (kill) fv_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) fv_q <= 1'b0;
    else     fv_q <= fv_d;

  assign fv = fv_q;
endmodule

module systolic_tile_sequencer #(
  parameter  int ROWS      = 8,
  parameter  int INWIDTH   = 8,
  parameter  int KMAX      = 16,
  parameter  int DRAIN_CYC = 15,
  localparam int KW        = $clog2(KMAX + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [KW-1:0]               k_len,
  input  logic                        abort,
  systolic_tile_sequencer_if.slave    s,
  input  logic [ROWS-1:0]             buf_full,
  output logic [ROWS-1:0]             buf_wr,
  output logic [INWIDTH-1:0]          buf_din_a,
  output logic [INWIDTH-1:0]          buf_din_w,
  output logic [ROWS-1:0]             buf_rd,
  output logic [ROWS-1:0]             feed_valid,
  output logic                        pe_clear,
  output logic                        busy,
  output logic                        done
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW = $clog2(KMAX + ROWS);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [KW-1:0] KMAX_K     = KW'(KMAX);
  localparam logic [RW-1:0] R_LAST     = RW'(ROWS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state_d, state_q;
  logic [KW-1:0]      k_d, k_q;
  logic [RW-1:0]      r_d, r_q;
  logic [KW-1:0]      c_d, c_q;
  logic [TW-1:0]      t_d, t_q;
  logic [DW-1:0]      dcnt_d, dcnt_q;
  logic [ROWS-1:0]    wr_d, wr_q;
  logic [INWIDTH-1:0] din_a_d, din_a_q, din_w_d, din_w_q;
  logic [TW-1:0]      t_last;
  logic               hs, feeding;

  assign s.in_ready = (state_q == S_LOAD) && !buf_full[r_q];
  assign hs         = s.in_valid && s.in_ready;
  assign t_last     = TW'(k_q) + TW'(ROWS - 2);
  assign feeding    = (state_q == S_FEED);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    c_d     = c_q;
    t_d     = t_q;
    dcnt_d  = dcnt_q;
    wr_d    = '0;
    din_a_d = din_a_q;
    din_w_d = din_w_q;
    case (state_q)
      S_IDLE: begin
        if (start && (k_len != '0)) begin
          state_d = S_LOAD;
          k_d     = (k_len > KMAX_K) ? KMAX_K : k_len;
          r_d     = '0;
          c_d     = '0;
        end
      end
      S_LOAD: begin
        if (hs) begin
          wr_d    = ROWS'(1) << r_q;
          din_a_d = s.a_in;
          din_w_d = s.w_in;
          if (r_q == R_LAST) begin
            r_d = '0;
            // Last row of the last column: the whole tile is in the buffers.
            if (c_q == k_q - KW'(1)) begin
              c_d     = '0;
              t_d     = '0;
              state_d = S_FEED;
            end else begin
              c_d = c_q + KW'(1);
            end
          end else begin
            r_d = r_q + RW'(1);
          end
        end
      end
      S_FEED: begin
        if (t_q == t_last) begin
          t_d     = '0;
          dcnt_d  = '0;
          state_d = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DRAIN_LAST) begin
          dcnt_d  = '0;
          state_d = S_DONE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      r_d     = '0;
      c_d     = '0;
      t_d     = '0;
      dcnt_d  = '0;
      wr_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      t_q     <= '0;
      dcnt_q  <= '0;
      wr_q    <= '0;
      din_a_q <= '0;
      din_w_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      c_q     <= c_d;
      t_q     <= t_d;
      dcnt_q  <= dcnt_d;
      wr_q    <= wr_d;
      din_a_q <= din_a_d;
      din_w_q <= din_w_d;
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    sts_row_lane #(.TW(TW), .KW(KW), .ROW(i)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .feeding (feeding),
      .kill    (abort),
      .t       (t_q),
      .k       (k_q),
      .rd      (buf_rd[i]),
      .fv      (feed_valid[i])
    );
  end

  assign buf_wr    = wr_q;
  assign buf_din_a = din_a_q;
  assign buf_din_w = din_w_q;
  assign pe_clear  = feeding && (t_q == '0);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
endmodule

// File: doc/systolic_tile_sequencer.md
Name: systolic_tile_sequencer

Overview:
- Schedules one tile of work for the ROWS-row systolic PE array.
- Phase 1: deserialises a single shared A/W input stream into the per-row input buffers, row-interleaved.
- Phase 2: issues diagonally skewed read enables so row i starts i cycles after row 0, then waits for the array to drain and signals completion.
- Sits between the external stream interface and the per-row A/W input FIFOs.

Parameters:
- ROWS, 8, number of PE rows and row buffers.
- INWIDTH, 8, A/W operand width.
- KMAX, 16, maximum vectors per row per tile.
- DRAIN_CYC, 15, cycles waited after the last read for the array to flush (nominally 2*ROWS-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a tile; honoured only in IDLE.
- k_len  in  $clog2(KMAX+1)  vectors per row; sampled when start is accepted.
- abort  in  1  synchronous cancel.
- in_valid  in  1  stream beat valid.
- in_ready  out  1  stream beat accepted when in_valid && in_ready.
- a_in  in  INWIDTH  activation operand.
- w_in  in  INWIDTH  weight operand.
- buf_full  in  ROWS  per-row buffer full flags.
- buf_wr  out  ROWS  one-hot row buffer write strobe.
- buf_din_a  out  INWIDTH  registered A write data.
- buf_din_w  out  INWIDTH  registered W write data.
- buf_rd  out  ROWS  per-row buffer read enable.
- feed_valid  out  ROWS  buf_rd delayed 1 cycle; marks valid lanes (others zero-masked).
- pe_clear  out  1  accumulator clear pulse.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle tile completion pulse.

Behaviour:
- Reset (async, rst=1): state=IDLE; all counters and outputs 0.
- FSM states: IDLE, LOAD, FEED, DRAIN, DONE.
- IDLE:
  - start with 1<=k_len<=KMAX: latch k_len, go to LOAD.
  - k_len>KMAX: latch KMAX.
  - k_len=0: start ignored, stay IDLE.
- LOAD:
  - Row pointer r and column counter c start at 0.
  - in_ready = (state==LOAD) && !buf_full[r].
  - On each handshake, next cycle: buf_wr=onehot(r), buf_din_a=a_in, buf_din_w=w_in (1-cycle registered latency). r increments; when r wraps from ROWS-1 to 0, c increments.
  - buf_wr is 0 in cycles with no handshake; buf_din_* hold their last value.
  - After beat ROWS*k_len is accepted, in_ready drops the next cycle and the state goes to FEED.
  - buf_full[r] high stalls the stream; no write occurs and r does not advance.
- FEED:
  - Cycle counter t runs 0..k_len+ROWS-2, then state goes to DRAIN.
  - buf_rd[i] = (t>=i) && (t<i+k_len), combinational from registered t.
  - feed_valid = buf_rd registered by 1 cycle.
  - pe_clear = 1 for exactly the first FEED cycle (t=0).
- DRAIN: counts DRAIN_CYC cycles, then goes to DONE.
- DONE: done=1 for one cycle, busy=1; next cycle state=IDLE, busy=0.
- Precedence:
  - abort in any non-IDLE state returns to IDLE next cycle: counters cleared, buf_wr/buf_rd/feed_valid 0 from that cycle on, no done.
  - abort has priority over start and over state advance. abort in IDLE has no effect.
- start is ignored while busy.
- Counter widths must hold KMAX*ROWS beats and KMAX+ROWS-1 feed cycles without wrap.
- Within one tile, each row receives exactly k_len writes and exactly k_len reads.

Test Plan:
- ROWS=4, k_len=3; stream beats a=1..12, w=101..112, in_valid held high -> exactly 12 handshakes; buf_wr sequence 0001,0010,0100,1000,0001,…; beat 5 writes row0 with a=5, w=105; in_ready=0 after beat 12.
- Same load with buf_full[2]=1 for 4 cycles when r=2 -> in_ready=0 and buf_wr=0 during the stall; row2 then receives a=3; total writes still 12.
- FEED with k_len=3, ROWS=4 -> 6 FEED cycles; buf_rd[0] high at t=0..2, buf_rd[3] high at t=3..5; feed_valid[3] high at t=4..6; single pe_clear pulse at t=0.
- DRAIN_CYC=7 -> done high exactly 8 cycles after the last FEED cycle, for 1 cycle; busy low the following cycle.
- start with k_len=0 -> stays IDLE. start with k_len=20 -> latches 16 and accepts 64 beats. start while in FEED -> ignored.
- Assert abort at LOAD beat 6 -> IDLE next cycle, no done. Assert rst mid-FEED -> buf_rd, busy and done go 0 immediately without waiting for a clock edge.
